reg_bank_wb: RTL

- Architectural register bank directly downstream of the writeback data selector; consumes its 32-bit write data plus destination index and write enable.
- Two asynchronous read ports feed the decode/operand-fetch stage.
- Per-register pending-write scoreboard (small up/down counters) gives decode a stall signal for RAW hazards against in-flight instructions.
- Register 0 reads as zero and is never written.

---
 rtl/reg_bank_wb.sv | 103 ++++++++++
 1 files changed

// File: rtl/reg_bank_wb.sv
// Architectural register bank with per-register pending-write scoreboard.
// Optional WB_BYPASS_EN forwards same-cycle writeback data/busy to the read ports.
module reg_bank_wb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] data_write,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              issue_full,
    output logic              stall,
    output logic              wb_underflow
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
    logic              wb_underflow_q, wb_underflow_d;
    logic              wr_en;
    logic              inc, dec;

    assign wr_en      = reg_write && (rd_addr != '0);
    assign issue_full = issue_valid && (issue_rd != '0) && (cnt_q[issue_rd] == CntMax);

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        inc    = 1'b0;
        dec    = 1'b0;
        if (wr_en) begin
            regs_d[rd_addr] = data_write;
        end
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            inc = issue_valid && (issue_rd == ADDR_W'(i)) && !issue_full;
            dec = reg_write && (rd_addr == ADDR_W'(i)) && (cnt_q[i] != '0);
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        regs_d[0] = '0;
        cnt_d[0]  = '0;
        wb_underflow_d = wb_underflow_q || (wr_en && (cnt_q[rd_addr] == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            wb_underflow_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            wb_underflow_q <= wb_underflow_d;
        end
    end

`ifdef WB_BYPASS_EN
    logic byp1, byp2;
    logic [CNT_W-1:0] cnt1, cnt2;

    assign byp1 = wr_en && (rd_addr == rs1_addr);
    assign byp2 = wr_en && (rd_addr == rs2_addr);

    // Writeback in flight retires one pending writer; guard against wrap on underflow.
    assign cnt1 = cnt_q[rs1_addr] - CNT_W'(byp1 && (cnt_q[rs1_addr] != '0));
    assign cnt2 = cnt_q[rs2_addr] - CNT_W'(byp2 && (cnt_q[rs2_addr] != '0));

    assign rs1_data = (rs1_addr == '0) ? '0 : (byp1 ? data_write : regs_q[rs1_addr]);
    assign rs2_data = (rs2_addr == '0) ? '0 : (byp2 ? data_write : regs_q[rs2_addr]);
    assign rs1_busy = (rs1_addr != '0) && (cnt1 != '0);
    assign rs2_busy = (rs2_addr != '0) && (cnt2 != '0);
`else
    assign rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
    assign rs1_busy = (rs1_addr != '0) && (cnt_q[rs1_addr] != '0);
    assign rs2_busy = (rs2_addr != '0) && (cnt_q[rs2_addr] != '0);
`endif

    assign stall        = rs1_busy || rs2_busy || issue_full;
    assign wb_underflow = wb_underflow_q;

endmodule
